// File: rtl/boot_loader.sv
// Byte-stream boot loader: packs a length-prefixed byte stream into 32-bit icache words.
// Optional trailing XOR checksum and error state are built only when BOOT_CSUM_EN is defined.
module boot_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        boot_up,
    output logic [7:0]  boot_addr,
    output logic [31:0] boot_datai,
    output logic        boot_web,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_FINISH,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [8:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] buffer;
    logic [7:0]  acc;
    logic        xfer;
    logic        last_word;

    assign xfer      = byte_valid & byte_ready;
    assign last_word = (word_idx == {1'b0, cnt});

    // Handshake and write strobe decode from the state register only, never from inputs.
    assign byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign boot_web   = (state != S_WRITE);
    assign boot_addr  = word_idx[7:0];
    assign boot_datai = buffer;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_HDR;
            S_HDR:    if (xfer) state_next = S_DATA;
            S_DATA:   if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef BOOT_CSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_FINISH;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef BOOT_CSUM_EN
            S_CSUM:   if (xfer) state_next = (byte_data == acc) ? S_FINISH : S_ERR;
            S_ERR:    if (start) state_next = S_HDR;
`endif
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and clears every datapath register, including the word buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_up  <= 1'b0;
            done     <= 1'b0;
            cnt      <= 8'h00;
            word_idx <= 9'd0;
            byte_idx <= 2'd0;
            buffer   <= 32'h0;
            acc      <= 8'h00;
        end else begin
            done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        boot_up  <= 1'b1;
                        word_idx <= 9'd0;
                        byte_idx <= 2'd0;
                        acc      <= 8'h00;
                    end
                end
                S_HDR: begin
                    if (xfer) cnt <= byte_data;
                end
                S_DATA: begin
                    if (xfer) begin
                        buffer[{byte_idx, 3'b000} +: 8] <= byte_data;
                        acc      <= acc ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    // Terminal compare against cnt keeps word_idx from wrapping past 0xFF.
                    if (!last_word) word_idx <= word_idx + 9'd1;
                end
                S_FINISH: begin
                    boot_up <= 1'b0;
                end
                S_ERR: begin
                    if (start) begin
                        word_idx <= 9'd0;
                        byte_idx <= 2'd0;
                        acc      <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOT_CSUM_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if ((state == S_IDLE || state == S_ERR) && start) begin
            error_q <= 1'b0;
        end else if (state == S_CSUM && xfer && byte_data != acc) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random byte streams compared against a word-packing model.
// Build with BOOT_CSUM_EN defined to exercise the checksum and error path.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        boot_up;
    logic [7:0]  boot_addr;
    logic [31:0] boot_datai;
    logic        boot_web;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] wr_q[$];
    int          done_cnt = 0;
    int          low_cnt  = 0;

    boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .boot_up    (boot_up),
        .boot_addr  (boot_addr),
        .boot_datai (boot_datai),
        .boot_web   (boot_web),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (boot_web === 1'b0) wr_q.push_back({boot_addr, boot_datai});
        if (done === 1'b1) done_cnt++;
        if (boot_up === 1'b1 && byte_ready === 1'b0) low_cnt++;
    end

    task automatic drive_bytes(input logic [7:0] s[$], input int gap, input bit spurious);
        int  idx    = 0;
        int  budget = 0;
        bit  sp_done = 1'b0;
        while (idx < s.size() && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (spurious && idx == 3 && !sp_done) begin
                start   = 1'b1;
                sp_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (int'($urandom_range(99)) < gap) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = s[idx];
                if (byte_ready) idx++;
            end
        end
        n_vec++;
        if (idx !== s.size()) begin
            n_err++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", idx, s.size());
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (boot_up !== 1'b1) begin
            n_err++;
            $display("FAIL boot_up_rise: got %b, required 1", boot_up);
        end
        wr_q.delete();
        done_cnt = 0;
        low_cnt  = 0;
    endtask

    // Full session: header cnt, payload words, optional checksum; compares icache writes to the model.
    task automatic run_load(input string name, input logic [7:0] cnt, input logic [7:0] data[$],
                            input int gap, input bit spurious);
        logic [7:0]  s[$];
        logic [7:0]  csum = 8'h00;
        logic [39:0] exp_w;
        int          n_words = int'(cnt) + 1;
        bit          seen = 1'b0;
        pulse_start();
        s.push_back(cnt);
        foreach (data[i]) begin
            s.push_back(data[i]);
            csum = csum ^ data[i];
        end
`ifdef BOOT_CSUM_EN
        s.push_back(csum);
`endif
        drive_bytes(s, gap, spurious);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                n_vec++;
                if (boot_up !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done_bootup: boot_up=%b with done, required 0", name, boot_up);
                end
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s done_timeout: done not seen, required pulse", name);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (wr_q.size() != n_words) begin
            n_err++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wr_q.size(), n_words);
        end
        for (int k = 0; k < n_words && k < wr_q.size(); k++) begin
            exp_w = {8'(k), data[4*k+3], data[4*k+2], data[4*k+1], data[4*k]};
            n_vec++;
            if (wr_q[k] !== exp_w) begin
                n_err++;
                $display("FAIL %s write_%0d: got addr %h data %h, required addr %h data %h",
                         name, k, wr_q[k][39:32], wr_q[k][31:0], exp_w[39:32], exp_w[31:0]);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d, required 1", name, done_cnt);
        end
        n_vec++;
        if (low_cnt != n_words + 1) begin
            n_err++;
            $display("FAIL %s ready_low_cycles: got %0d, required %0d", name, low_cnt, n_words + 1);
        end
        n_vec++;
        if (error !== 1'b0 || boot_up !== 1'b0 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_outputs: error=%b boot_up=%b ready=%b, required 0 0 0",
                     name, error, boot_up, byte_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({boot_up, boot_web, boot_addr, boot_datai, byte_ready, done, error} !==
            {1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: up=%b web=%b addr=%h data=%h ready=%b done=%b err=%b, required 0 1 00 0 0 0 0",
                     boot_up, boot_web, boot_addr, boot_datai, byte_ready, done, error);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d[$] = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load("basic", 8'h00, d, 0, 1'b0);
    endtask

    task automatic test_full_image();
        logic [7:0] d[$];
        for (int i = 0; i < 1024; i++) d.push_back(8'(i));
        run_load("full_image", 8'hFF, d, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] d[$];
        for (int i = 0; i < 24; i++) d.push_back(8'($urandom));
        run_load("continuous", 8'd5, d, 0, 1'b0);
        run_load("gapped", 8'd5, d, 40, 1'b0);
    endtask

    task automatic test_random_loads();
        logic [7:0] d[$];
        int         words;
        for (int r = 0; r < 4; r++) begin
            d.delete();
            words = int'($urandom_range(8, 1));
            for (int i = 0; i < 4 * words; i++) d.push_back(8'($urandom));
            run_load("random", 8'(words - 1), d, int'($urandom_range(50)), 1'b0);
        end
    endtask

    task automatic test_spurious_start();
        logic [7:0] d[$];
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        run_load("spurious_start", 8'd2, d, 0, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] s[$] = '{8'h00, 8'hAA, 8'hBB};
        logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        drive_bytes(s, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (boot_up !== 1'b0 || boot_web !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_word: up=%b web=%b ready=%b done=%b, required 0 1 0 0",
                     boot_up, boot_web, byte_ready, done);
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if (wr_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_word_writes: got %0d writes, required 0", wr_q.size());
        end
        run_load("after_reset", 8'h00, d, 0, 1'b0);
    endtask

`ifdef BOOT_CSUM_EN
    task automatic test_bad_checksum();
        logic [7:0] s[$] = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        logic [7:0] d[$] = '{8'h78, 8'h56, 8'h34, 8'h12};
        pulse_start();
        drive_bytes(s, 0, 1'b0);
        repeat (10) @(negedge clk);
        n_vec++;
        if (error !== 1'b1 || boot_up !== 1'b1 || byte_ready !== 1'b0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL bad_checksum: error=%b up=%b ready=%b dones=%0d, required 1 1 0 0",
                     error, boot_up, byte_ready, done_cnt);
        end
        n_vec++;
        if (wr_q.size() != 1) begin
            n_err++;
            $display("FAIL bad_checksum_writes: got %0d, required 1", wr_q.size());
        end
        run_load("recover", 8'h00, d, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_image();
        test_backpressure();
        test_random_loads();
        test_spurious_start();
        test_reset_mid_word();
`ifdef BOOT_CSUM_EN
        test_bad_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
